bit_packer: RTL

BIT_PACKER -- requirements
Module: bit_packer

---
 rtl/bit_packer_pkg.sv | 16 +
 rtl/bit_packer_acc.sv | 89 ++++++++
 rtl/bit_packer.sv | 87 ++++++++
 3 files changed

// File: rtl/bit_packer_pkg.sv
// Shared types and helpers for the bit_packer block.
package bit_packer_pkg;

  // Accumulator occupancy: no bits, partial word, word waiting for the output register.
  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL
  } state_e;

  // Width of a counter able to hold 0..width.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_packer_acc.sv
// Bit accumulator for bit_packer: places accepted bits, tracks the bit count and
// decides when a complete or flushed word moves to the output register.
module bit_packer_acc
  import bit_packer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned CW       = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_accept,
  input  logic             i_bit,
  input  logic             i_flush,
  input  logic             i_out_free,
  output logic             o_ready,
  output logic             o_emit,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  state_e           r_state, w_state_n;
  logic [WIDTH-1:0] r_data, w_data_n, w_acc_data;
  logic [CW-1:0]    r_count, w_count_n, w_acc_count, w_idx;

  // Target position of the next bit; only used while count < WIDTH.
  assign w_idx       = LSB_FIRST ? r_count : (CW'(WIDTH - 1) - r_count);
  // Word and count including a bit accepted this cycle (unfilled positions stay 0).
  assign w_acc_data  = i_accept ? (r_data | (WIDTH'(i_bit) << w_idx)) : r_data;
  assign w_acc_count = r_count + CW'(i_accept);

  assign o_ready = (r_state != FULL);

  // Next-state, word hand-off and emitted word selection.
  always_comb begin
    w_state_n = r_state;
    w_data_n  = r_data;
    w_count_n = r_count;
    o_emit    = 1'b0;
    o_data    = r_data;
    o_count   = r_count;
    case (r_state)
      FULL: begin
        // Flush is ignored here; the held word leaves as soon as the register frees.
        if (i_out_free) begin
          o_emit    = 1'b1;
          w_state_n = EMPTY;
          w_data_n  = '0;
          w_count_n = '0;
        end
      end
      default: begin
        o_data  = w_acc_data;
        o_count = w_acc_count;
        // A same-cycle bit is included before a flush; a completing bit yields one word.
        if ((w_acc_count == CW'(WIDTH)) || (i_flush && (w_acc_count != '0))) begin
          if (i_out_free) begin
            o_emit    = 1'b1;
            w_state_n = EMPTY;
            w_data_n  = '0;
            w_count_n = '0;
          end else begin
            w_state_n = FULL;
            w_data_n  = w_acc_data;
            w_count_n = w_acc_count;
          end
        end else begin
          w_data_n  = w_acc_data;
          w_count_n = w_acc_count;
          w_state_n = (w_acc_count == '0) ? EMPTY : FILL;
        end
      end
    endcase
  end

  // Accumulator state, partial word and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      r_data  <= w_data_n;
      r_count <= w_count_n;
    end
  end

endmodule

// File: rtl/bit_packer.sv
// Serial-to-parallel bit packer: output register and handshakes around bit_packer_acc.
// Optional feature: define BIT_PACKER_PARITY_EN to add the registered out_parity output.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned CW       = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count
`ifdef BIT_PACKER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic             w_acc_ready, w_accept, w_out_free, w_emit;
  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    w_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_count;

  assign in_ready   = w_acc_ready & ~rst;
  assign w_accept   = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  bit_packer_acc #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_accept  (w_accept),
    .i_bit     (in_bit),
    .i_flush   (flush),
    .i_out_free(w_out_free),
    .o_ready   (w_acc_ready),
    .o_emit    (w_emit),
    .o_data    (w_word),
    .o_count   (w_count)
  );

  // Output register: load on hand-off, drop valid once consumed, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_count <= w_count;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

`ifdef BIT_PACKER_PARITY_EN
  logic r_parity;

  // Parity registered alongside the word it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_emit) begin
      r_parity <= ^w_word;
    end
  end

  assign out_parity = r_parity;
`endif

endmodule
